// File: rtl/wt_ctrl_pkg.sv
// Shared types and defaults for the weight-fetch controller.
// Contents:
//   state_t     - controller state (IDLE, FETCH, DRAIN)
//   DEF_*       - default parameter values for the controller and its FIFO
//   CNT_W       - run-length counter width for the default address width
//   ptr_width() - FIFO pointer width for a given depth
package wt_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int DEF_ADDR_WIDTH = 11;
    localparam int DEF_DATA_WIDTH = 256;
    localparam int DEF_READ_LAT   = 1;
    localparam int DEF_FIFO_DEPTH = 4;

    // One extra bit so a run covering the whole memory is representable.
    localparam int CNT_W = DEF_ADDR_WIDTH + 1;

    function automatic int ptr_width(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/wt_fetch_fifo.sv
// Small synchronous FIFO holding returned weight words plus their last flag.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   flush        - empties the FIFO; overrides push and pop
//   push, din    - write one entry
//   pop          - remove the head entry (caller guarantees not empty)
//   dout         - head entry (valid when !empty)
//   count, empty - occupancy
module wt_fetch_fifo
    import wt_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_WIDTH + 1,
    parameter int DEPTH = DEF_FIFO_DEPTH,
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [PTR_W:0]   count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            count_r <= count_r + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        end
    end

    // Storage array; contents need no reset because occupancy gates their use.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign empty = (count_r == {(PTR_W+1){1'b0}});

endmodule

// File: rtl/weight_fetch_ctrl.sv
// Weight SRAM sequencer: streams a contiguous run of words from SRAM port B
// to the datapath over valid/ready, and lets the host write through port A
// only while no fetch is in progress.
// Ports:
//   clka, reset_n              - clock (also SRAM clka/clkb), async active-low reset
//   start, base_addr, word_cnt - fetch request, sampled in IDLE
//   abort                      - cancel an active fetch
//   busy, done                 - status; done pulses one cycle on completion/abort
//   w_valid/w_ready/w_data/w_last - weight stream to the datapath
//   hw_valid/hw_ready/hw_addr/hw_data - host write request
//   ena, wea, addra, dina      - SRAM port A
//   enb, addrb, doutb          - SRAM port B
module weight_fetch_ctrl
    import wt_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int READ_LAT   = DEF_READ_LAT,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clka,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_cnt,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_last,
    input  logic                  hw_valid,
    output logic                  hw_ready,
    input  logic [ADDR_WIDTH-1:0] hw_addr,
    input  logic [DATA_WIDTH-1:0] hw_data,
    output logic                  ena,
    output logic                  wea,
    output logic [ADDR_WIDTH-1:0] addra,
    output logic [DATA_WIDTH-1:0] dina,
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb
);

    localparam int CW    = ADDR_WIDTH + 1;
    localparam int PTR_W = ptr_width(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 2;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [ADDR_WIDTH-1:0] base_r;
    logic [CW-1:0]         cnt_r;
    logic [CW-1:0]         issued_r;
    logic [CW-1:0]         push_idx_r;
    logic [READ_LAT-1:0]   pipe_r;
    logic                  abort_r;
    logic                  abort_nxt_s;
    logic                  done_r;
    logic                  done_nxt_s;
    logic                  busy_r;
    logic                  load_s;
    logic                  issue_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  flush_s;
    logic                  last_in_s;
    logic                  head_last_s;
    logic                  fifo_empty_s;
    logic [PTR_W:0]        fifo_count_s;
    logic [DATA_WIDTH:0]   fifo_dout_s;
    logic [OCC_W-1:0]      inflight_s;
    logic [OCC_W-1:0]      occ_s;

    // Number of reads still travelling through the SRAM pipeline.
    always_comb begin
        inflight_s = '0;
        for (int i = 0; i < READ_LAT; i++) begin
            inflight_s = inflight_s + OCC_W'(pipe_r[i]);
        end
    end

    // A read is only issued if its word is guaranteed a FIFO slot on return.
    assign occ_s       = inflight_s + OCC_W'(fifo_count_s);
    assign issue_s     = (state_r == FETCH) && !abort && (issued_r < cnt_r)
                         && (occ_s < OCC_W'(FIFO_DEPTH));
    assign flush_s     = abort && (state_r != IDLE);
    // While an abort is pending, returns of cancelled reads are dropped.
    assign push_s      = pipe_r[READ_LAT-1] && !abort_r && !flush_s;
    assign pop_s       = !fifo_empty_s && w_ready;
    assign last_in_s   = (push_idx_r == (cnt_r - CW'(1)));
    assign head_last_s = fifo_dout_s[DATA_WIDTH];

    // Next-state and completion decisions.
    always_comb begin
        state_nxt_s = state_r;
        done_nxt_s  = 1'b0;
        abort_nxt_s = abort_r;
        load_s      = 1'b0;
        case (state_r)
            IDLE: begin
                abort_nxt_s = 1'b0;
                if (start) begin
                    if (word_cnt == {CW{1'b0}}) begin
                        done_nxt_s = 1'b1;
                    end else begin
                        load_s      = 1'b1;
                        state_nxt_s = FETCH;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                if (abort) begin
                    state_nxt_s = DRAIN;
                    abort_nxt_s = 1'b1;
                end else if (issued_r == cnt_r) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            DRAIN: begin
                if (abort_r) begin
                    // Cancelled run: finish only once every outstanding read has returned.
                    if (pipe_r == {READ_LAT{1'b0}}) begin
                        state_nxt_s = IDLE;
                        done_nxt_s  = 1'b1;
                        abort_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end else if (abort) begin
                    abort_nxt_s = 1'b1;
                end else if (pop_s && head_last_s) begin
                    state_nxt_s = IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                abort_nxt_s = 1'b0;
            end
        endcase
    end

    // State, run counters and in-flight read tracking.
    always_ff @(posedge clka or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            base_r     <= '0;
            cnt_r      <= '0;
            issued_r   <= '0;
            push_idx_r <= '0;
            pipe_r     <= '0;
            abort_r    <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= done_nxt_s;
            abort_r <= abort_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            if (load_s) begin
                base_r     <= base_addr;
                cnt_r      <= word_cnt;
                issued_r   <= '0;
                push_idx_r <= '0;
            end else begin
                if (issue_s) begin
                    issued_r <= issued_r + CW'(1);
                end
                if (push_s) begin
                    push_idx_r <= push_idx_r + CW'(1);
                end
            end
            pipe_r[0] <= issue_s;
            for (int i = 1; i < READ_LAT; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    wt_fetch_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clka),
        .rst_n (reset_n),
        .flush (flush_s),
        .push  (push_s),
        .din   ({last_in_s, doutb}),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .empty (fifo_empty_s)
    );

    assign busy    = busy_r;
    assign done    = done_r;
    assign w_valid = !fifo_empty_s;
    assign w_data  = fifo_dout_s[DATA_WIDTH-1:0];
    assign w_last  = head_last_s && !fifo_empty_s;

    // Host writes pass straight through to port A, but only while idle.
    assign hw_ready = reset_n && (state_r == IDLE) && hw_valid;
    assign ena      = hw_ready;
    assign wea      = hw_ready;
    assign addra    = hw_addr;
    assign dina     = hw_data;

    // Port B address wraps modulo the memory size.
    assign enb   = issue_s;
    assign addrb = base_r + issued_r[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Randomized scoreboard bench for weight_fetch_ctrl with a 1-cycle SRAM model.
module tb_weight_fetch_ctrl;

    localparam int AW = 11;
    localparam int DW = 256;
    localparam int MEM_WORDS = 2048;

    logic          clka = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   word_cnt;
    logic          abort;
    logic          busy;
    logic          done;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] w_data;
    logic          w_last;
    logic          hw_valid;
    logic          hw_ready;
    logic [AW-1:0] hw_addr;
    logic [DW-1:0] hw_data;
    logic          ena;
    logic          wea;
    logic [AW-1:0] addra;
    logic [DW-1:0] dina;
    logic          enb;
    logic [AW-1:0] addrb;
    logic [DW-1:0] doutb;

    weight_fetch_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .READ_LAT   (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clka      (clka),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .word_cnt  (word_cnt),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_last    (w_last),
        .hw_valid  (hw_valid),
        .hw_ready  (hw_ready),
        .hw_addr   (hw_addr),
        .hw_data   (hw_data),
        .ena       (ena),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .enb       (enb),
        .addrb     (addrb),
        .doutb     (doutb)
    );

    always #5 clka = ~clka;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Scoreboard state shared between stimulus and monitor.
    logic [DW:0]   exp_q[$];
    logic [AW-1:0] addr_q[$];
    logic [DW-1:0] ref_mem [MEM_WORDS];
    int  reads_n, hs_n, done_n;
    int  first_valid_cyc, first_hs_cyc, last_hs_cyc, done_cyc, e0;
    bit  in_abort = 1'b0;
    int  ready_mode = 0;
    bit  prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    function automatic logic [DW-1:0] seed_word(input int a);
        logic [DW-1:0] w;
        for (int k = 0; k < 8; k++) begin
            w[k*32 +: 32] = (a * 32'h9E3779B9) ^ (k * 32'h01010101) ^ 32'h5A5A0000;
        end
        return w;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int k = 0; k < 8; k++) begin
            w[k*32 +: 32] = $urandom;
        end
        return w;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // SRAM model: port A write, port B registered read (latency 1).
    logic sram_init = 1'b0;
    logic [DW-1:0] mem [MEM_WORDS];
    always @(posedge clka) begin
        if (!sram_init) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= seed_word(i);
            sram_init <= 1'b1;
        end else begin
            if (ena && wea) mem[addra] <= dina;
            if (enb) doutb <= mem[addrb];
        end
    end

    always @(posedge clka) cyc <= cyc + 1;

    // Ready pattern generator.
    initial begin
        int pat;
        pat = 0;
        w_ready = 1'b0;
        forever begin
            @(posedge clka);
            #1;
            case (ready_mode)
                0: w_ready = 1'b1;
                1: w_ready = 1'($urandom_range(0, 1));
                2: begin
                    w_ready = (pat == 0) || (pat == 3);
                    pat = (pat + 1) % 4;
                end
                default: w_ready = 1'b0;
            endcase
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks protocol rules.
    initial begin
        logic [DW:0]   e;
        logic [AW-1:0] a;
        forever begin
            @(negedge clka);
            if (!reset_n) begin
                prev_stall = 1'b0;
            end else begin
                if (enb) begin
                    reads_n++;
                    if (addr_q.size() == 0) begin
                        chk("addrb_unexpected", 1, 0);
                    end else begin
                        a = addr_q.pop_front();
                        chk("addrb", DW'(addrb), DW'(a));
                    end
                end
                if (prev_stall && !in_abort) begin
                    chk("hold_valid", DW'(w_valid), 1);
                    chk("hold_data", w_data, prev_data);
                    chk("hold_last", DW'(w_last), DW'(prev_last));
                end
                if (w_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (w_valid && w_ready) begin
                    hs_n++;
                    last_hs_cyc = cyc;
                    if (first_hs_cyc < 0) first_hs_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        chk("word_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("w_data", w_data, e[DW-1:0]);
                        chk("w_last", DW'(w_last), DW'(e[DW]));
                    end
                end
                chk("outstanding_le_4", DW'((reads_n - hs_n) <= 4), 1);
                if (done) begin
                    done_n++;
                    done_cyc = cyc;
                    chk("done_busy_excl", DW'(busy), 0);
                end
                if (busy && hw_valid) chk("hw_blocked", DW'({hw_ready, ena, wea}), 0);
                prev_stall = w_valid && !w_ready;
                prev_data  = w_data;
                prev_last  = w_last;
            end
        end
    end

    task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(posedge clka); #1;
        hw_valid = 1'b1; hw_addr = a; hw_data = d;
        @(negedge clka);
        chk("hw_ready_idle", DW'(hw_ready), 1);
        @(posedge clka); #1;
        hw_valid = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic begin_run(input logic [AW-1:0] base, input int cnt);
        logic [AW-1:0] a;
        for (int i = 0; i < cnt; i++) begin
            a = base + AW'(i);
            exp_q.push_back({(i == cnt - 1), ref_mem[a]});
            addr_q.push_back(a);
        end
        reads_n = 0; hs_n = 0; done_n = 0;
        first_valid_cyc = -1; first_hs_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
        @(posedge clka); #1;
        start = 1'b1; base_addr = base; word_cnt = (AW+1)'(cnt);
        @(posedge clka); #1;
        start = 1'b0;
        e0 = cyc;
    endtask

    task automatic run_fetch(input logic [AW-1:0] base, input int cnt, input int abort_at);
        bit got;
        begin_run(base, cnt);
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(posedge clka);
            #1;
            in_abort = 1'b1; abort = 1'b1;
            @(posedge clka); #1;
            abort = 1'b0;
            exp_q.delete(); addr_q.delete();
            @(negedge clka);
            chk("abort_wvalid_drop", DW'(w_valid), 0);
        end
        got = 1'b0;
        for (int t = 0; t < 5000 && !got; t++) begin
            @(negedge clka);
            if (done) got = 1'b1;
        end
        chk("done_seen", DW'(got), 1);
        if (got) begin
            chk("busy_at_done", DW'(busy), 0);
            if (hw_valid) chk("hw_ready_after_done", DW'(hw_ready), 1);
        end
        @(negedge clka);
        chk("done_pulse_width", DW'(done), 0);
        chk("done_single", DW'(done_n), 1);
        if (abort_at == 0) begin
            chk("words_delivered", DW'(hs_n), DW'(cnt));
            chk("reads_issued", DW'(reads_n), DW'(cnt));
            chk("scoreboard_empty", DW'(exp_q.size()), 0);
        end
        in_abort = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        reset_n = 1'b0; start = 1'b0; base_addr = '0; word_cnt = '0; abort = 1'b0;
        hw_valid = 1'b0; hw_addr = '0; hw_data = '0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = seed_word(i);
        #2;
        chk("rst_outputs", DW'({busy, done, w_valid, w_last, enb, ena, wea, hw_ready}), 0);
        #21 reset_n = 1'b1;

        // Directed: known data, latency, back-to-back delivery.
        for (int i = 0; i < 4; i++) begin
            d = '0; d[7:0] = 8'hA0 + 8'(i);
            host_write(AW'(i), d);
        end
        ready_mode = 0;
        run_fetch(11'h000, 4, 0);
        chk("first_valid_latency", DW'(first_valid_cyc - e0), 2);
        chk("consecutive_words", DW'(last_hs_cyc - first_hs_cyc), 3);
        chk("done_after_last", DW'(done_cyc - last_hs_cyc), 1);

        // Address wrap at the top of memory.
        run_fetch(11'h7FE, 4, 0);

        // Backpressure pattern 1-0-0-1.
        ready_mode = 2;
        run_fetch(11'h010, 8, 0);

        // Zero-length request.
        ready_mode = 0;
        reads_n = 0; done_n = 0;
        @(posedge clka); #1;
        start = 1'b1; word_cnt = '0; base_addr = 11'h123;
        @(posedge clka); #1;
        start = 1'b0;
        @(negedge clka);
        chk("zero_cnt_done", DW'(done), 1);
        chk("zero_cnt_busy", DW'(busy), 0);
        repeat (3) @(negedge clka);
        chk("zero_cnt_no_reads", DW'(reads_n), 0);
        chk("zero_cnt_done_once", DW'(done_n), 1);

        // Host write held during a fetch is blocked until IDLE.
        d = rand_word();
        hw_addr = 11'h100; hw_data = d; hw_valid = 1'b1;
        ref_mem[11'h100] = d;
        run_fetch(11'h020, 6, 0);
        hw_valid = 1'b0;
        run_fetch(11'h100, 1, 0);

        // Abort three cycles into a long fetch, then a clean run.
        ready_mode = 1;
        run_fetch(11'h040, 16, 3);
        run_fetch(11'h050, 5, 0);

        // Asynchronous reset in the middle of a fetch.
        ready_mode = 0;
        begin_run(11'h080, 16);
        repeat (4) @(posedge clka);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_outputs", DW'({busy, done, w_valid, w_last, enb, ena, wea, hw_ready}), 0);
        exp_q.delete(); addr_q.delete();
        @(posedge clka); #3 reset_n = 1'b1;
        run_fetch(11'h080, 6, 0);

        // Randomized runs.
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < 2; k++) host_write(AW'($urandom_range(0, MEM_WORDS - 1)), rand_word());
            ready_mode = $urandom_range(0, 2);
            run_fetch(AW'($urandom_range(0, MEM_WORDS - 1)), $urandom_range(1, 24), 0);
        end

        // Whole-memory run.
        ready_mode = 0;
        run_fetch(11'h005, MEM_WORDS, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
- Sequences the dual-port weight SRAM (blk_mem_gen_1) for the TM compute datapath.
- Drives read port B to stream a contiguous run of weight words to the clause/class-sum datapath over a valid/ready interface.
- Absorbs SRAM read latency with a credit-tracked output FIFO.
- Arbitrates port A (host weight writes) so that writes are only accepted while no fetch is in progress.

Parameters:
- ADDR_WIDTH, 11, SRAM address width
- DATA_WIDTH, 256, weight word width
- READ_LAT, 1, SRAM port-B read latency in cycles, 1..2
- FIFO_DEPTH, 4, output buffer entries, power of 2, >= READ_LAT+2

Ports:
- clka  in  1  sole clock; also drives SRAM clka and clkb
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle fetch request, honoured only in IDLE
- base_addr  in  ADDR_WIDTH  first word address, sampled with start
- word_cnt  in  ADDR_WIDTH+1  number of words to fetch, sampled with start
- abort  in  1  cancels an active fetch
- busy  out  1  high in FETCH or DRAIN
- done  out  1  one-cycle pulse at completion or abort
- w_valid  out  1  weight word available
- w_ready  in  1  datapath accepts word
- w_data  out  DATA_WIDTH  weight word
- w_last  out  1  marks final word of the run
- hw_valid  in  1  host write request
- hw_ready  out  1  host write accepted this cycle
- hw_addr  in  ADDR_WIDTH  host write address
- hw_data  in  DATA_WIDTH  host write data
- ena, wea  out  1 each  SRAM port A controls
- addra  out  ADDR_WIDTH  SRAM port A address
- dina  out  DATA_WIDTH  SRAM port A data
- enb  out  1  SRAM port B enable
- addrb  out  ADDR_WIDTH  SRAM port B address
- doutb  in  DATA_WIDTH  SRAM port B read data

Behaviour:
- Reset (async, active-low): state=IDLE, counters=0, FIFO empty. All outputs 0: busy, done, w_valid, w_last, enb, ena, wea, hw_ready.
- IDLE:
  - hw_ready = hw_valid, combinational.
  - When hw_valid is high: ena=wea=1, addra=hw_addr, dina=hw_data.
  - start with word_cnt=0: go straight to done pulse next cycle; no reads issued, state stays IDLE.
  - start with word_cnt>0: latch base_addr/word_cnt, go to FETCH. A host write in the same cycle as start still completes.
- FETCH:
  - hw_ready=0, ena=0.
  - Issue one read (enb=1, addrb=base+issued, modulo 2^ADDR_WIDTH, wrap from max to 0) per cycle while both hold: issued<word_cnt, and inflight+fifo_count < FIFO_DEPTH.
  - When issued==word_cnt, go to DRAIN.
- In-flight data: a READ_LAT-stage valid shift register tracks in-flight reads. doutb is pushed into the FIFO exactly READ_LAT cycles after enb.
- Output:
  - w_valid = FIFO not empty; w_data = FIFO head.
  - Pop on w_valid&&w_ready.
  - w_last=1 on the head entry whose sequence index is word_cnt-1.
  - Minimum latency from start to first w_valid: READ_LAT+1 cycles.
  - Sustained throughput is 1 word/cycle with w_ready held high.
- DRAIN: no new reads. Leave when the last word is handshaken; done pulses the next cycle, state goes to IDLE.
- Backpressure:
  - w_ready low: issue stalls once credits are exhausted.
  - No word may be dropped or duplicated.
  - w_data/w_last must stay stable while w_valid&&!w_ready.
- Abort, in FETCH or DRAIN:
  - Stop issuing immediately and flush the FIFO.
  - Discard in-flight returns, which may take up to READ_LAT cycles.
  - done pulses once the pipeline is empty, then IDLE.
  - w_valid drops the cycle after abort.
  - abort in IDLE is ignored.
- start while busy is ignored.
- busy = state!=IDLE. done and busy are never high together except in the done cycle, where busy=0.
- Counters are ADDR_WIDTH+1 bits, so word_cnt=2^ADDR_WIDTH (full memory) is legal.

Decomposition:
- Shared package wt_ctrl_pkg:
  - state enum {IDLE, FETCH, DRAIN}
  - default widths
  - localparam CNT_W=ADDR_WIDTH+1
  - FIFO pointer width function clog2(FIFO_DEPTH)
- One sub-module, wt_fetch_fifo: synchronous FIFO with DATA_WIDTH+1-bit entries (data+last), push/pop/flush, count output, same async reset.

Test Plan:
- Host writes to addr 0..3 (data 0xA0..0xA3), then start base=0 cnt=4 with w_ready=1 -> w_data A0,A1,A2,A3 on consecutive cycles; first w_valid 2 cycles after start (READ_LAT=1); w_last on A3; done 1 cycle after A3 handshake.
- start base=0x7FE cnt=4 -> addrb sequence 0x7FE,0x7FF,0x000,0x001; four words returned in order.
- cnt=8, w_ready toggled 1-0-0-1 repeating -> exactly 8 words, in order, no duplicates; held data stable while stalled; inflight+fifo_count never exceeds 4.
- start cnt=0 -> done pulse next cycle; enb never asserted; busy stays 0.
- hw_valid held high during a cnt=6 fetch -> hw_ready=0 and wea=0 throughout; write accepted in the first IDLE cycle after done.
- abort 3 cycles into a cnt=16 fetch, plus reset_n asserted mid-fetch in a second run -> abort: w_valid low next cycle, single done pulse, IDLE. Reset: all outputs 0 immediately and asynchronously; next start fetches correctly.
